// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_pkg
// Purpose  : Shared constants and types for the seven-segment capture block.
//            Segment patterns are active-low, bit order gfedcba (bit 6 = g).
// Contents : SEG_0..SEG_9, SEG_BLANK, VAL_BLANK, VAL_ERR, cap_state_e,
//            anode helper functions (operate on an 8-bit anode vector
//            padded with 1s above the used positions).
// Revision : 1.0  initial release
// ============================================================================
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] VAL_BLANK = 4'hF;
  localparam logic [3:0] VAL_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_HELD   = 2'd3
  } cap_state_e;

  // True when exactly one active-low anode is asserted.
  function automatic logic one_low(input logic [7:0] an);
    return ($countones(~an) == 1);
  endfunction

  // Position of the asserted (low) anode; only meaningful when one_low().
  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_capture_if
// Purpose  : Bundle of the display bus (an/seg), the decoded digit state and
//            the valid/ready change-event stream of the capture block.
// Modports : master - display driver / event consumer side
//            slave  - capture block side
// Revision : 1.0  initial release
// ============================================================================
interface sevenseg_capture_if #(
  parameter int NUM_DIGITS = 6
);
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   err;
  logic                    upd_valid;
  logic                    upd_ready;
  logic [2:0]              upd_idx;
  logic [3:0]              upd_val;
  logic                    frame_done;
  logic                    overflow;

  modport master (
    output an, seg, upd_ready,
    input  digits, blank, err, upd_valid, upd_idx, upd_val, frame_done, overflow
  );

  modport slave (
    input  an, seg, upd_ready,
    output digits, blank, err, upd_valid, upd_idx, upd_val, frame_done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/sevenseg_decode.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_decode
// Purpose  : Combinational active-low gfedcba pattern -> {value, blank, err};
//            inverse of the display encoder.
// Ports    : seg_i   - 7-bit segment pattern (0 = lit)
//            value_o - decimal value, VAL_BLANK for all-off, VAL_ERR otherwise
//            blank_o - pattern was all segments off
//            err_o   - pattern is not a decimal digit or blank
// Revision : 1.0  initial release
// ============================================================================
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    value_o = VAL_ERR;
    blank_o = 1'b0;
    err_o   = 1'b1;
    case (seg_i)
      SEG_0:     begin value_o = 4'd0; err_o = 1'b0; end
      SEG_1:     begin value_o = 4'd1; err_o = 1'b0; end
      SEG_2:     begin value_o = 4'd2; err_o = 1'b0; end
      SEG_3:     begin value_o = 4'd3; err_o = 1'b0; end
      SEG_4:     begin value_o = 4'd4; err_o = 1'b0; end
      SEG_5:     begin value_o = 4'd5; err_o = 1'b0; end
      SEG_6:     begin value_o = 4'd6; err_o = 1'b0; end
      SEG_7:     begin value_o = 4'd7; err_o = 1'b0; end
      SEG_8:     begin value_o = 4'd8; err_o = 1'b0; end
      SEG_9:     begin value_o = 4'd9; err_o = 1'b0; end
      SEG_BLANK: begin value_o = VAL_BLANK; blank_o = 1'b1; err_o = 1'b0; end
      default:   ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_capture
// Purpose  : Receive side of a multiplexed seven-segment bus. Synchronizes the
//            anode/segment lines, waits for a pattern to be stable for
//            STABLE_CYCLES samples, decodes it into the per-position digit
//            registers and emits a one-deep valid/ready change-event stream.
// Ports    : clk, reset_n (async, active-low)
//            bus (slave) - an, seg, upd_ready in; digits, blank, err,
//                          upd_valid, upd_idx, upd_val, frame_done,
//                          overflow out
// Revision : 1.0  initial release
// ============================================================================
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  sevenseg_capture_if.slave bus
);

  localparam int         SW     = NUM_DIGITS + 7;
  // Count at which the next equal sample completes the stability window.
  localparam logic [7:0] C_LAST = 8'(STABLE_CYCLES - 1);

  // Sample layout: {an, seg}
  logic [SW-1:0]           sync1_q, sync2_q, prev_q, acc_q;
  logic [7:0]              samp_an_pad, acc_an_pad;
  logic                    samp_legal;
  logic [2:0]              acc_pos;
  logic [3:0]              dec_val;
  logic                    dec_blank, dec_err;
  logic                    evt_new;

  cap_state_e              state_q;
  logic [7:0]              count_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   blank_q, err_q, ever_q, seen_q;
  logic                    upd_valid_q, frame_done_q, overflow_q;
  logic [2:0]              upd_idx_q;
  logic [3:0]              upd_val_q;

  // Two-flop synchronizer; idle bus (all high) is the reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {bus.an, bus.seg};
      sync2_q <= sync1_q;
    end
  end

  // Unused upper anode positions read as inactive.
  always_comb begin
    samp_an_pad                 = '1;
    samp_an_pad[NUM_DIGITS-1:0] = sync2_q[SW-1:7];
    acc_an_pad                  = '1;
    acc_an_pad[NUM_DIGITS-1:0]  = acc_q[SW-1:7];
  end

  assign samp_legal = one_low(samp_an_pad);
  assign acc_pos    = low_index(acc_an_pad);

  // The accepted pattern is frozen in acc_q, so decode and commit see the
  // same value even if the bus moves during the ACCEPT cycle.
  sevenseg_decode u_decode (
    .seg_i   (acc_q[6:0]),
    .value_o (dec_val),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  always_comb begin
    evt_new = !ever_q[acc_pos]
           || (digits_q[4*acc_pos +: 4] != dec_val)
           || (blank_q[acc_pos] != dec_blank)
           || (err_q[acc_pos] != dec_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT;
      count_q      <= '0;
      prev_q       <= '1;
      acc_q        <= '1;
      digits_q     <= '0;
      blank_q      <= '1;
      err_q        <= '0;
      ever_q       <= '0;
      seen_q       <= '0;
      upd_valid_q  <= 1'b0;
      upd_idx_q    <= '0;
      upd_val_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      prev_q       <= sync2_q;
      // ACCEPT is never back-to-back, so a full seen set is always observed
      // one cycle after the completing commit and cleared before the next.
      frame_done_q <= &seen_q;
      if (&seen_q) seen_q <= '0;

      if (upd_valid_q && bus.upd_ready) upd_valid_q <= 1'b0;

      case (state_q)
        ST_WAIT: begin
          if (samp_legal) begin
            state_q <= ST_SETTLE;
            count_q <= 8'd1;
          end
        end

        ST_SETTLE: begin
          if (!samp_legal) begin
            state_q <= ST_WAIT;
            count_q <= '0;
          end else if (sync2_q != prev_q) begin
            count_q <= 8'd1;
          end else if (count_q >= C_LAST) begin
            state_q <= ST_ACCEPT;
            acc_q   <= sync2_q;
            count_q <= '0;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end

        ST_ACCEPT: begin
          state_q                   <= ST_HELD;
          digits_q[4*acc_pos +: 4]  <= dec_val;
          blank_q[acc_pos]          <= dec_blank;
          err_q[acc_pos]            <= dec_err;
          ever_q[acc_pos]           <= 1'b1;
          seen_q[acc_pos]           <= 1'b1;
          if (evt_new) begin
            // Slot is free, or is being consumed this very cycle.
            if (!upd_valid_q || bus.upd_ready) begin
              upd_valid_q <= 1'b1;
              upd_idx_q   <= acc_pos;
              upd_val_q   <= dec_val;
            end else begin
              overflow_q  <= 1'b1;
            end
          end
        end

        ST_HELD: begin
          if (!samp_legal) begin
            state_q <= ST_WAIT;
            count_q <= '0;
          end else if (sync2_q != acc_q) begin
            state_q <= ST_SETTLE;
            count_q <= 8'd1;
          end
        end

        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign bus.digits     = digits_q;
  assign bus.blank      = blank_q;
  assign bus.err        = err_q;
  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_idx    = upd_idx_q;
  assign bus.upd_val    = upd_val_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_capture
// Purpose  : Self-checking bench for sevenseg_capture. Expected change events
//            are queued when a pattern is driven and compared when the DUT
//            hands them over on the valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_sevenseg_capture;
  import sevenseg_pkg::*;

  localparam int ND = 6;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset_n;

  sevenseg_capture_if #(.NUM_DIGITS(ND)) bif ();

  sevenseg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] val;
  } evt_t;

  evt_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   evt_cnt   = 0;
  int   frame_cnt = 0;

  logic [3:0] m_val   [ND];
  logic       m_blank [ND];
  logic       m_err   [ND];
  logic       m_ever  [ND];

  // Reference decode: {value, blank, err}
  function automatic logic [5:0] tb_dec(input logic [6:0] s);
    case (s)
      7'h40:   return {4'h0, 2'b00};
      7'h79:   return {4'h1, 2'b00};
      7'h24:   return {4'h2, 2'b00};
      7'h30:   return {4'h3, 2'b00};
      7'h19:   return {4'h4, 2'b00};
      7'h12:   return {4'h5, 2'b00};
      7'h02:   return {4'h6, 2'b00};
      7'h78:   return {4'h7, 2'b00};
      7'h00:   return {4'h8, 2'b00};
      7'h18:   return {4'h9, 2'b00};
      7'h7F:   return {4'hF, 2'b10};
      default: return {4'hE, 2'b01};
    endcase
  endfunction

  function automatic logic [4*ND-1:0] m_digits();
    logic [4*ND-1:0] d;
    for (int i = 0; i < ND; i++) d[4*i +: 4] = m_val[i];
    return d;
  endfunction

  // One clock: scoreboard pop on handshake at the falling edge, then advance
  // to just after the next rising edge.
  task automatic tick();
    evt_t e;
    @(negedge clk);
    if (reset_n === 1'b1 && bif.upd_valid === 1'b1 && bif.upd_ready === 1'b1) begin
      checks++;
      evt_cnt++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event_unexpected: got idx=%0d val=%h, required no event",
                 bif.upd_idx, bif.upd_val);
      end else begin
        e = exp_q.pop_front();
        if (bif.upd_idx !== e.idx || bif.upd_val !== e.val) begin
          failures++;
          $display("FAIL event_value: got idx=%0d val=%h, required idx=%0d val=%h",
                   bif.upd_idx, bif.upd_val, e.idx, e.val);
        end
      end
    end
    if (bif.frame_done === 1'b1) frame_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic model_commit(input int pos, input logic [6:0] s, input bit push_ok);
    logic [5:0] d;
    logic       chg;
    evt_t       e;
    d   = tb_dec(s);
    chg = !m_ever[pos] || m_val[pos] != d[5:2] || m_blank[pos] != d[1] || m_err[pos] != d[0];
    m_val[pos]   = d[5:2];
    m_blank[pos] = d[1];
    m_err[pos]   = d[0];
    m_ever[pos]  = 1'b1;
    if (chg && push_ok) begin
      e.idx = 3'(pos);
      e.val = d[5:2];
      exp_q.push_back(e);
    end
  endtask

  // Show pattern s on position pos for a number of cycles; anything held
  // for 8+ cycles is long enough to be accepted.
  task automatic show(input int pos, input logic [6:0] s, input int cycles, input bit push_ok);
    bif.an  = ~(6'(1) << pos);
    bif.seg = s;
    if (cycles >= 8) model_commit(pos, s, push_ok);
    repeat (cycles) tick();
  endtask

  task automatic test_reset();
    bif.an        = '1;
    bif.seg       = '1;
    bif.upd_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < ND; i++) begin
      m_val[i] = 4'h0; m_blank[i] = 1'b1; m_err[i] = 1'b0; m_ever[i] = 1'b0;
    end
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    checks++;
    if (bif.digits !== '0) begin
      failures++; $display("FAIL reset_digits: got %h, required 0", bif.digits);
    end
    checks++;
    if (bif.blank !== 6'h3F || bif.err !== 6'h00) begin
      failures++; $display("FAIL reset_blank_err: got blank=%b err=%b, required 111111/000000", bif.blank, bif.err);
    end
    checks++;
    if (bif.upd_valid !== 1'b0 || bif.upd_idx !== 3'd0 || bif.upd_val !== 4'd0) begin
      failures++; $display("FAIL reset_event: got v=%b idx=%0d val=%h, required 0/0/0", bif.upd_valid, bif.upd_idx, bif.upd_val);
    end
    checks++;
    if (bif.frame_done !== 1'b0 || bif.overflow !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got fd=%b ovf=%b, required 0/0", bif.frame_done, bif.overflow);
    end
    checks++;
    if (dut.state_q !== ST_WAIT) begin
      failures++; $display("FAIL reset_state: got %0d, required %0d", dut.state_q, ST_WAIT);
    end
  endtask

  task automatic test_single_digit();
    bif.upd_ready = 1'b0;
    bif.an  = 6'b111110;
    bif.seg = 7'h30;
    model_commit(0, 7'h30, 1'b1);
    repeat (6) tick();
    checks++;
    if (bif.upd_valid !== 1'b0) begin
      failures++; $display("FAIL latency_early: got upd_valid=%b after edge 5, required 0", bif.upd_valid);
    end
    tick();
    checks++;
    if (bif.upd_valid !== 1'b1 || bif.upd_idx !== 3'd0 || bif.upd_val !== 4'd3 || bif.digits[3:0] !== 4'd3) begin
      failures++; $display("FAIL latency_commit: got v=%b idx=%0d val=%h dig=%h, required 1/0/3/3",
                           bif.upd_valid, bif.upd_idx, bif.upd_val, bif.digits[3:0]);
    end
    repeat (20) tick();
    checks++;
    if (bif.upd_valid !== 1'b1 || bif.upd_idx !== 3'd0 || bif.upd_val !== 4'd3 || bif.overflow !== 1'b0) begin
      failures++; $display("FAIL held_no_reaccept: got v=%b idx=%0d val=%h ovf=%b, required 1/0/3/0",
                           bif.upd_valid, bif.upd_idx, bif.upd_val, bif.overflow);
    end
    bif.upd_ready = 1'b1;
    tick();
    bif.upd_ready = 1'b0;
    tick();
    checks++;
    if (bif.upd_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL single_consume: got v=%b pending=%0d, required 0/0", bif.upd_valid, exp_q.size());
    end
    bif.upd_ready = 1'b1;
  endtask

  task automatic test_scan();
    logic [6:0] pat[ND];
    int         e0;
    pat = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    for (int pass = 0; pass < 2; pass++) begin
      frame_cnt = 0;
      e0 = evt_cnt;
      for (int p = 0; p < ND; p++) show(p, pat[p], 10, 1'b1);
      repeat (4) tick();
      checks++;
      if (evt_cnt - e0 != ((pass == 0) ? ND : 0) || exp_q.size() != 0) begin
        failures++; $display("FAIL scan_events pass%0d: got %0d events pending=%0d, required %0d/0",
                             pass, evt_cnt - e0, exp_q.size(), (pass == 0) ? ND : 0);
      end
      checks++;
      if (frame_cnt != 1) begin
        failures++; $display("FAIL scan_frame_done pass%0d: got %0d cycles high, required 1", pass, frame_cnt);
      end
    end
  endtask

  task automatic test_ghost();
    int e0;
    e0 = evt_cnt;
    show(2, 7'h30, 10, 1'b1);
    show(2, 7'h00, 2, 1'b1);
    show(2, 7'h30, 10, 1'b1);
    checks++;
    if (bif.digits[11:8] !== 4'd3 || evt_cnt != e0) begin
      failures++; $display("FAIL ghost_reject: got dig=%h events=%0d, required 3/0", bif.digits[11:8], evt_cnt - e0);
    end
  endtask

  task automatic test_multi_anode();
    int e0;
    int bad;
    e0  = evt_cnt;
    bad = 0;
    bif.an  = 6'b111100;
    bif.seg = 7'h12;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 3 && dut.state_q !== ST_WAIT) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL multi_anode_state: got %0d cycles outside WAIT, required 0", bad);
    end
    checks++;
    if (bif.digits !== m_digits() || evt_cnt != e0) begin
      failures++; $display("FAIL multi_anode_commit: got dig=%h events=%0d, required %h/0",
                           bif.digits, evt_cnt - e0, m_digits());
    end
  endtask

  task automatic test_blank_err();
    show(4, 7'h7F, 10, 1'b1);
    checks++;
    if (bif.blank[4] !== 1'b1 || bif.err[4] !== 1'b0 || bif.digits[19:16] !== 4'hF) begin
      failures++; $display("FAIL blank_pos4: got blank=%b err=%b dig=%h, required 1/0/F",
                           bif.blank[4], bif.err[4], bif.digits[19:16]);
    end
    show(4, 7'h55, 10, 1'b1);
    checks++;
    if (bif.blank[4] !== 1'b0 || bif.err[4] !== 1'b1 || bif.digits[19:16] !== 4'hE) begin
      failures++; $display("FAIL err_pos4: got blank=%b err=%b dig=%h, required 0/1/E",
                           bif.blank[4], bif.err[4], bif.digits[19:16]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL blank_err_events: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    bif.upd_ready = 1'b0;
    show(1, 7'h78, 10, 1'b1);
    checks++;
    if (bif.upd_valid !== 1'b1 || bif.upd_idx !== 3'd1 || bif.upd_val !== 4'd7 || bif.overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_first: got v=%b idx=%0d val=%h ovf=%b, required 1/1/7/0",
                           bif.upd_valid, bif.upd_idx, bif.upd_val, bif.overflow);
    end
    show(1, 7'h00, 10, 1'b0);
    checks++;
    if (bif.upd_idx !== 3'd1 || bif.upd_val !== 4'd7 || bif.overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_second: got idx=%0d val=%h ovf=%b, required 1/7/1",
                           bif.upd_idx, bif.upd_val, bif.overflow);
    end
    show(1, 7'h18, 10, 1'b0);
    checks++;
    if (bif.upd_valid !== 1'b1 || bif.upd_idx !== 3'd1 || bif.upd_val !== 4'd7 ||
        bif.overflow !== 1'b1 || bif.digits[7:4] !== 4'd9) begin
      failures++; $display("FAIL ovf_third: got v=%b idx=%0d val=%h ovf=%b dig=%h, required 1/1/7/1/9",
                           bif.upd_valid, bif.upd_idx, bif.upd_val, bif.overflow, bif.digits[7:4]);
    end
    bif.upd_ready = 1'b1;
    tick();
    bif.upd_ready = 1'b0;
    tick();
    checks++;
    if (bif.upd_valid !== 1'b0 || bif.overflow !== 1'b1 || exp_q.size() != 0) begin
      failures++; $display("FAIL ovf_drain: got v=%b ovf=%b pending=%0d, required 0/1/0",
                           bif.upd_valid, bif.overflow, exp_q.size());
    end
  endtask

  task automatic test_reset_discard();
    bif.upd_ready = 1'b0;
    show(3, 7'h40, 10, 1'b0);
    show(3, 7'h00, 3, 1'b0);
    test_reset();
    repeat (10) tick();
    checks++;
    if (bif.upd_valid !== 1'b0 || bif.digits !== '0 || bif.overflow !== 1'b0) begin
      failures++; $display("FAIL reset_discard: got v=%b dig=%h ovf=%b, required 0/0/0",
                           bif.upd_valid, bif.digits, bif.overflow);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bif.an        = '1;
    bif.seg       = '1;
    bif.upd_ready = 1'b0;
    test_reset();
    test_single_digit();
    test_scan();
    test_ghost();
    test_multi_anode();
    test_blank_err();
    test_overflow();
    test_reset_discard();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
